// File: rtl/freq_uart_report.sv
// rtl/freq_uart_report.sv - 8N1 UART reporter for latched 8-digit BCD frequency readings
module freq_uart_report #(
    parameter int BAUD_DIV = 434
) (
    input  logic        fpga_clk,
    input  logic        reset,
    input  logic [31:0] bcd_value,
    input  logic        value_valid,
    output logic        uart_tx,
    output logic        busy,
    output logic        dropped
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [31:0]   hold;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    char_idx;
    logic [3:0]    first_idx;
    logic [7:0]    cur_char;
    logic [2:0]    digit_pos;
    logic [3:0]    digit;
    logic          baud_wrap;

    // char_idx encoding: digit k is k+2, CR is 1, LF is 0; it counts down to 0.
    always_comb begin
        first_idx = 4'd2;
        for (int i = 1; i < 8; i++) begin
            if (bcd_value[i*4 +: 4] != 4'd0) first_idx = 4'(i + 2);
        end
    end

    always_comb begin
        digit_pos = 3'(char_idx - 4'd2);
        digit     = hold[{digit_pos, 2'b00} +: 4];
        cur_char  = 8'h0A;
        if (char_idx == 4'd1)
            cur_char = 8'h0D;
        else if (char_idx >= 4'd2)
            cur_char = (digit > 4'd9) ? 8'h3F : {4'h3, digit};
    end

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold     <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= value_valid && busy;
            if (state != IDLE)
                baud_cnt <= baud_wrap ? '0 : baud_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        hold     <= bcd_value;
                        char_idx <= first_idx;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        uart_tx <= cur_char[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            uart_tx <= cur_char[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (char_idx == 4'd0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            char_idx <= char_idx - 4'd1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_uart_report.sv
// tb/tb_freq_uart_report.sv - directed self-checking bench for freq_uart_report
module tb_freq_uart_report;

    localparam int BD = 4;

    logic        fpga_clk = 1'b0;
    logic        reset;
    logic [31:0] bcd_value;
    logic        value_valid;
    logic        uart_tx;
    logic        busy;
    logic        dropped;

    int tests_run = 0;
    int tests_failed = 0;
    int busy_total = 0;
    int drop_total = 0;

    freq_uart_report #(.BAUD_DIV(BD)) dut (
        .fpga_clk    (fpga_clk),
        .reset       (reset),
        .bcd_value   (bcd_value),
        .value_valid (value_valid),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .dropped     (dropped)
    );

    always #5 fpga_clk = ~fpga_clk;

    always @(negedge fpga_clk) begin
        if (busy === 1'b1) busy_total++;
        if (dropped === 1'b1) drop_total++;
    end

    // All tasks are entered and left at a falling clock edge.
    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int t = 0;
        ok = 1'b1;
        b  = 8'h00;
        while (uart_tx !== 1'b0 && t < 400) begin
            @(negedge fpga_clk);
            t++;
        end
        if (t >= 400) begin
            ok = 1'b0;
            return;
        end
        @(negedge fpga_clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge fpga_clk);
            b[i] = uart_tx;
        end
        repeat (BD) @(negedge fpga_clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic recv_check(input logic [79:0] exp, input int n, input string name);
        logic [7:0] b;
        logic [7:0] e;
        bit ok;
        for (int i = 0; i < n; i++) begin
            recv_byte(b, ok);
            e = exp[(n-1-i)*8 +: 8];
            tests_run++;
            if (!ok || b !== e) begin
                tests_failed++;
                $display("FAIL %s byte%0d: got %02h (framing ok=%0d), expected %02h", name, i, b, ok, e);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy === 1'b1 && t < 1000) begin
            @(negedge fpga_clk);
            t++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle timeout: busy=%b, expected 0", name, busy);
        end
    endtask

    task automatic strobe(input logic [31:0] v);
        bcd_value   = v;
        value_valid = 1'b1;
        @(negedge fpga_clk);
        value_valid = 1'b0;
    endtask

    task automatic check_start(input string name);
        tests_run++;
        if (uart_tx !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s latency: tx=%b busy=%b, expected tx=0 busy=1", name, uart_tx, busy);
        end
    endtask

    task automatic check_busy_len(input int b0, input int n, input string name);
        tests_run++;
        if (busy_total - b0 != n * 10 * BD) begin
            tests_failed++;
            $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_total - b0, n * 10 * BD);
        end
    endtask

    task automatic run_frame(input logic [31:0] v, input logic [79:0] exp, input int n, input string name);
        int b0 = busy_total;
        strobe(v);
        check_start(name);
        recv_check(exp, n, name);
        wait_idle(name);
        check_busy_len(b0, n, name);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge fpga_clk);
        tests_run++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: tx=%b busy=%b dropped=%b, expected 1 0 0", uart_tx, busy, dropped);
        end
        reset = 1'b0;
        repeat (5) @(negedge fpga_clk);
    endtask

    task automatic test_blanking;
        tests_run++;
        if (uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_tx: got %b, expected 1", uart_tx);
        end
        run_frame(32'h00012345, 80'h31323334350D0A, 7, "blank12345");
        run_frame(32'h00000000, 80'h300D0A, 3, "zeros");
    endtask

    task automatic test_full_and_invalid;
        repeat (7) @(negedge fpga_clk);
        run_frame(32'h99999999, 80'h39393939393939390D0A, 10, "nines");
        run_frame(32'h000000A5, 80'h3F350D0A, 4, "invalidA5");
    endtask

    task automatic test_overrun;
        int b0 = busy_total;
        int d0 = drop_total;
        repeat (3) @(negedge fpga_clk);
        b0 = busy_total;
        strobe(32'h00000042);
        check_start("overrun");
        fork
            recv_check(80'h34320D0A, 4, "overrun");
            begin
                repeat (49) @(negedge fpga_clk);
                bcd_value   = 32'h00000777;
                value_valid = 1'b1;
                @(negedge fpga_clk);
                value_valid = 1'b0;
            end
        join
        wait_idle("overrun");
        check_busy_len(b0, 4, "overrun");
        tests_run++;
        if (drop_total - d0 != 1) begin
            tests_failed++;
            $display("FAIL overrun dropped cycles: got %0d, expected 1", drop_total - d0);
        end
        b0 = busy_total;
        repeat (60) @(negedge fpga_clk);
        tests_run++;
        if (busy_total != b0 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun no_second_frame: busy cycles %0d tx=%b, expected 0 and 1", busy_total - b0, uart_tx);
        end
    endtask

    task automatic test_back_to_back;
        run_frame(32'h00000007, 80'h370D0A, 3, "b2b_first");
        run_frame(32'h00100000, 80'h3130303030300D0A, 8, "b2b_second");
    endtask

    task automatic test_reset_mid_frame;
        repeat (2) @(negedge fpga_clk);
        strobe(32'h00012345);
        repeat (54) @(negedge fpga_clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || dropped !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid async: tx=%b busy=%b dropped=%b, expected 1 0 0", uart_tx, busy, dropped);
        end
        repeat (3) @(negedge fpga_clk);
        reset = 1'b0;
        repeat (60) @(negedge fpga_clk);
        tests_run++;
        if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid quiet: tx=%b busy=%b, expected 1 0", uart_tx, busy);
        end
        run_frame(32'h00012345, 80'h31323334350D0A, 7, "after_reset");
    endtask

    task automatic test_isolation;
        int b0;
        repeat (4) @(negedge fpga_clk);
        b0 = busy_total;
        strobe(32'h87654321);
        check_start("isolation");
        fork
            recv_check(80'h38373635343332310D0A, 10, "isolation");
            begin
                for (int i = 0; i < 500 && busy === 1'b1; i++) begin
                    bcd_value = $urandom;
                    @(negedge fpga_clk);
                end
            end
        join
        wait_idle("isolation");
        check_busy_len(b0, 10, "isolation");
    endtask

    initial begin
        reset       = 1'b1;
        bcd_value   = 32'h0;
        value_valid = 1'b0;
        test_reset;
        test_blanking;
        test_full_and_invalid;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        test_isolation;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
